// File: rtl/coin_credit_collector.sv
// Coin front-end for the vending core: saturating credit, held order handshake, refund on cancel.
// Optional inactivity auto-refund is compiled in when COIN_TIMEOUT_EN is defined.
module coin_credit_collector #(
  parameter int MAX_CREDIT     = 99,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       select_valid,
  input  logic [2:0] select_type,
  input  logic [3:0] select_amount,
  input  logic       cancel,
  input  logic       order_ready,
  output logic       order_valid,
  output logic [6:0] customer_money,
  output logic [2:0] supply_type,
  output logic [3:0] customer_amount,
  output logic [6:0] credit,
  output logic       coin_reject,
  output logic       refund_valid,
  output logic [6:0] refund_amount,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, ORDER, REFUND} state_t;

  localparam logic [7:0] MAX_SUM = 8'(MAX_CREDIT);

  state_t     state;
  logic [7:0] coin_val;
  logic [7:0] sum;
  logic       coin_fits;
  logic [6:0] next_credit;
  logic       sel_ok;
  logic       timed_out;
  logic       cancel_any;

  always_comb begin
    coin_val = 8'd0;
    case (coin_type)
      2'd0:    coin_val = 8'd1;
      2'd1:    coin_val = 8'd2;
      2'd2:    coin_val = 8'd5;
      default: coin_val = 8'd10;
    endcase
    sum         = {1'b0, credit} + coin_val;
    coin_fits   = (sum <= MAX_SUM);
    next_credit = (coin_valid && coin_fits) ? sum[6:0] : credit;
    sel_ok      = select_valid && (select_amount != 4'd0);
  end

`ifdef COIN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TW-1:0] idle_timer;

  assign timed_out = (state == COLLECT) && (idle_timer == TW'(TIMEOUT_CYCLES - 1));

  // Counts COLLECT cycles since entry or since the last accepted coin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_timer <= '0;
    end else if (state != COLLECT || timed_out || cancel || (coin_valid && coin_fits)) begin
      idle_timer <= '0;
    end else begin
      idle_timer <= idle_timer + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  assign cancel_any = cancel || timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      order_valid     <= 1'b0;
      customer_money  <= '0;
      supply_type     <= '0;
      customer_amount <= '0;
      credit          <= '0;
      coin_reject     <= 1'b0;
      refund_valid    <= 1'b0;
      refund_amount   <= '0;
      busy            <= 1'b0;
    end else begin
      coin_reject   <= 1'b0;
      refund_valid  <= 1'b0;
      refund_amount <= '0;
      case (state)
        IDLE, COLLECT: begin
          // Cancel outranks both coin and select; only a non-zero credit is refunded.
          if (cancel_any) begin
            coin_reject <= coin_valid;
            if (state == COLLECT) begin
              refund_valid  <= 1'b1;
              refund_amount <= credit;
              credit        <= '0;
              state         <= REFUND;
            end
          end else begin
            coin_reject <= coin_valid && !coin_fits;
            credit      <= next_credit;
            if (sel_ok) begin
              state           <= ORDER;
              order_valid     <= 1'b1;
              busy            <= 1'b1;
              customer_money  <= next_credit;
              supply_type     <= select_type;
              customer_amount <= select_amount;
            end else if (next_credit != 7'd0) begin
              state <= COLLECT;
            end
          end
        end
        ORDER: begin
          coin_reject <= coin_valid;
          if (order_ready) begin
            order_valid     <= 1'b0;
            busy            <= 1'b0;
            credit          <= '0;
            customer_money  <= '0;
            supply_type     <= '0;
            customer_amount <= '0;
            state           <= IDLE;
          end
        end
        REFUND: begin
          coin_reject <= coin_valid;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/coin_credit_collector.md
# coin_credit_collector

Upstream front-end for the vending core.
- Collects coin pulses into a saturating credit register.
- Captures a product selection and presents `customer_money`, `supply_type` and `customer_amount` to the core as one held order with a valid/ready handshake.
- Returns credit on cancel and, optionally, on inactivity timeout.
- Its `credit` output also feeds the two-digit seven-segment display path while coins are being inserted.

## Interface
- `MAX_CREDIT`, 99: credit ceiling, two-digit display limit; must be ≤ 127.
- `TIMEOUT_CYCLES`, 1000: inactivity limit in COLLECT; used only with `COIN_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `coin_valid` in 1: one-cycle coin strobe.
- `coin_type` in 2: coin value 0→1, 1→2, 2→5, 3→10.
- `select_valid` in 1: one-cycle selection strobe.
- `select_type` in 3: product index.
- `select_amount` in 4: quantity; 0 means the strobe is ignored.
- `cancel` in 1: one-cycle refund request.
- `order_ready` in 1: vending core accepts the order.
- `order_valid` out 1: order presented to the core.
- `customer_money` out 7: credit frozen into the order.
- `supply_type` out 3: frozen `select_type`.
- `customer_amount` out 4: frozen `select_amount`.
- `credit` out 7: live credit.
- `coin_reject` out 1: one-cycle pulse when a coin is refused.
- `refund_valid` out 1: one-cycle refund pulse.
- `refund_amount` out 7: refund value; 0 when `refund_valid` is low.
- `busy` out 1: high in ORDER.

## Operation
- **IDLE** (credit 0):
  - Accepted coin → COLLECT.
  - Valid select → ORDER with `customer_money` = 0; the core flags the error.
  - Cancel has no effect.
- **COLLECT** (credit > 0):
  - Coin adds its value.
  - Valid select → ORDER.
  - Cancel → REFUND.
  - Timeout → REFUND.
- **ORDER**:
  - `order_valid` is 1 and the order fields are frozen.
  - Coins are rejected.
  - Cancel and select are ignored.
  - On `order_valid` & `order_ready`: credit cleared → IDLE.
  - The core computes change; this block does not refund after an order.
- **REFUND**: one state cycle.
  - `refund_valid` is 1 and `refund_amount` = credit before the clear.
  - Credit is cleared and the state goes to IDLE.
- **Arithmetic**: an 8-bit intermediate sum credit + coin value.
  - If the sum exceeds `MAX_CREDIT`, the coin is rejected and credit is unchanged.
  - There is never wrap-around.
- **Simultaneous events**:
  - Coin + select in COLLECT or IDLE: the coin is added first, and the order carries the new credit. If that coin overflows, it is rejected and the order carries the old credit.
  - Cancel + select: cancel wins.
  - Cancel + coin: the coin is rejected and the old credit is refunded.
  - Coin in IDLE + cancel: the coin is rejected and there is no refund.

## Timing
- **Reset**: all outputs are 0 and the state is IDLE, asynchronously on `rst_n` low. Credit dropped mid-operation is lost with no refund pulse.
- **Coin** sampled at edge N: `credit` is updated after N. `coin_reject` is high for the cycle after N.
- **Select** sampled at edge N: `order_valid`, `busy` and the order fields are valid from the cycle after N.
- **Order handshake**:
  - Fields stay stable while `order_valid` is 1.
  - `order_ready` is ignored while `order_valid` is 0.
  - Completion edge M: from M+1, `order_valid` = 0, `busy` = 0 and `credit` = 0. A new coin is accepted at M+1.
- **Cancel** at edge N: in cycle N+1, `refund_valid` = 1, `refund_amount` = old credit and `credit` = 0. In N+2, `refund_valid` = 0 and the state is IDLE.
- **Timeout counter** (with the macro):
  - Cleared on entry to COLLECT and on every accepted coin.
  - Increments each COLLECT cycle.
  - Reaching `TIMEOUT_CYCLES`-1 acts as cancel at that edge.

## Configuration
- `COIN_TIMEOUT_EN` defined: the timeout counter and auto-refund are compiled in as described.
- Not defined: no counter logic. COLLECT holds credit indefinitely until select or cancel. `TIMEOUT_CYCLES` is unused.

## Test plan
- Order path:
  - Stimulus: coins types 3, 2, 1, then select type 3 amount 1, `order_ready` low for 3 cycles, then high.
  - Response: `credit` is 17. Order is `customer_money` 17, `supply_type` 3, `customer_amount` 1, stable while waiting. After acceptance, `order_valid` 0, `credit` 0, `busy` 0.
- Saturation:
  - Stimulus: build credit 95, insert coin type 3, then coin type 1.
  - Response: the 10-unit coin gives one `coin_reject` pulse and credit stays 95. The 2-unit coin gives credit 97. Credit reaches exactly 99 and never exceeds it.
- Cancel:
  - Stimulus: credit 12, cancel.
  - Response: one-cycle `refund_valid` with `refund_amount` 12, then `credit` 0. Cancel + coin type 3 with credit 12 gives a refund of 12 plus `coin_reject`.
- Timeout, with `COIN_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8:
  - Stimulus: coin type 2, then idle.
  - Response: refund of 5 after 8 cycles.
  - Without the macro: `credit` is still 5 after 100 cycles.
- ORDER robustness:
  - Stimulus: during ORDER, insert coin type 3, then cancel, then select type 7.
  - Response: the coin is rejected, and the fields and credit are unchanged.
  - Stimulus: drive `rst_n` low mid-ORDER.
  - Response: all outputs 0 immediately.
- Zero-amount select:
  - Stimulus: credit 10, select with `select_amount` 0.
  - Response: ignored; state stays COLLECT and `order_valid` stays 0.
